// File: rtl/nibble_serial_comparator.sv
// Time-multiplexed magnitude comparator: one 4-bit nibble per clock, MSN first,
// terminating at the first differing nibble with EQ/LT/GT cascade semantics.
module nibble_serial_comparator #(
  parameter int unsigned M = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         aEQb,
  output logic         aLTb,
  output logic         aGTb
);

  localparam int unsigned STAGES = M / 4;
  localparam int unsigned IW     = (STAGES > 1) ? $clog2(STAGES) : 1;

  typedef enum logic {
    S_IDLE,
    S_COMPARE
  } state_t;

  state_t          state_q, state_d;
  logic [M-1:0]    a_q, a_d;
  logic [M-1:0]    b_q, b_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            eq_q, eq_d;
  logic            lt_q, lt_d;
  logic            gt_q, gt_d;
  logic            done_q, done_d;
  logic [3:0]      nib_a, nib_b;

  // Current nibble pair selected by idx
  assign nib_a = 4'(a_q >> {idx_q, 2'b00});
  assign nib_b = 4'(b_q >> {idx_q, 2'b00});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IW'(STAGES - 1);
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        // First differing nibble decides; equality needs the last nibble too
        if (nib_a > nib_b) begin
          {eq_d, lt_d, gt_d} = 3'b001;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (nib_a < nib_b) begin
          {eq_d, lt_d, gt_d} = 3'b010;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (idx_q == '0) begin
          {eq_d, lt_d, gt_d} = 3'b100;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_COMPARE);
  assign done = done_q;
  assign aEQb = eq_q;
  assign aLTb = lt_q;
  assign aGTb = gt_q;

endmodule
